// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
//   ps_width() : width of the present-state / fill-count fields (clog2(SEQ_LEN+1))
//   sat_inc()  : saturating increment of a counter of a given width (1..32)
//   seq_op_e   : per-edge operation selected from the input strobes
package seq_det_pkg;

  localparam int unsigned MAX_SEQ_LEN = 8;
  localparam logic [3:0]  DEF_PATTERN = 4'b1010;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_SAMPLE = 2'd2
  } seq_op_e;

  function automatic int unsigned ps_width(input int unsigned seq_len);
    return $clog2(seq_len + 1);
  endfunction

  // Holds at all-ones of the given width instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [32:0] lim;
    lim = (33'd1 << width) - 33'd1;
    if ({1'b0, val} >= lim) return val;
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_match_len.sv
// Prefix/suffix comparator for the sequence detector (purely combinational).
//   i_hist       : last SEQ_LEN samples, bit 0 = newest
//   i_fill       : how many of those samples are real (0..SEQ_LEN)
//   i_pat        : active pattern, bit SEQ_LEN-1 = first bit of the sequence
//   o_len        : longest k in 0..SEQ_LEN whose last k samples equal the first k pattern bits
//   o_len_proper : same, restricted to k < SEQ_LEN
module seq_match_len
  import seq_det_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned PS_W    = ps_width(SEQ_LEN)
) (
  input  logic [SEQ_LEN-1:0] i_hist,
  input  logic [PS_W-1:0]    i_fill,
  input  logic [SEQ_LEN-1:0] i_pat,
  output logic [PS_W-1:0]    o_len,
  output logic [PS_W-1:0]    o_len_proper
);

  logic [SEQ_LEN-1:0] w_mask;
  logic [SEQ_LEN-1:0] w_prefix;
  logic               w_hit;

  // Try every length; the last hit is the longest. Unfilled samples never match.
  always_comb begin
    o_len        = '0;
    o_len_proper = '0;
    w_mask       = '0;
    w_prefix     = '0;
    w_hit        = 1'b0;
    for (int unsigned k = 1; k <= SEQ_LEN; k++) begin
      w_mask   = ~({SEQ_LEN{1'b1}} << k);
      // First k pattern bits aligned so the first one lands on the oldest of the last k samples.
      w_prefix = i_pat >> (SEQ_LEN - k);
      w_hit    = (PS_W'(k) <= i_fill) && (((i_hist ^ w_prefix) & w_mask) == '0);
      if (w_hit) begin
        o_len = PS_W'(k);
        if (k < SEQ_LEN) o_len_proper = PS_W'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial bit-sequence detector with runtime pattern reload,
// overlap/non-overlap mode and a saturating match counter.
//   fsm_clk, clr  : clock, asynchronous active-high clear
//   din/din_valid : serial bit and its one-cycle sample strobe
//   overlap       : 1 = overlapping detection (sampled on the match edge only)
//   pat_load/pat_in : load a new pattern; wins over din_valid on the same edge
//   seq_det       : match indication
//   match_cnt     : saturating number of matches
//   ps            : number of pattern bits currently matched
// Build option: define SEQ_DET_STRETCH_EN to stretch seq_det with a
// STRETCH_W-bit down-counter so the LED is visible; otherwise seq_det is a
// one-cycle pulse and no stretch counter exists.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned         SEQ_LEN   = 4,
  parameter logic [SEQ_LEN-1:0]  PATTERN   = SEQ_LEN'(DEF_PATTERN),
  parameter int unsigned         CNT_W     = 8,
  parameter int unsigned         STRETCH_W = 24
) (
  input  logic                            fsm_clk,
  input  logic                            clr,
  input  logic                            din,
  input  logic                            din_valid,
  input  logic                            overlap,
  input  logic                            pat_load,
  input  logic [SEQ_LEN-1:0]              pat_in,
  output logic                            seq_det,
  output logic [CNT_W-1:0]                match_cnt,
  output logic [ps_width(SEQ_LEN)-1:0]    ps
);

  localparam int unsigned PS_W = ps_width(SEQ_LEN);

  if ((SEQ_LEN < 2) || (SEQ_LEN > MAX_SEQ_LEN) || (CNT_W < 1) || (CNT_W > 32) ||
      (STRETCH_W < 1)) begin : g_param_check
    $error("seq_detector_param: unsupported parameter set");
  end

  // The SEQ_LEN-sample window is r_hist (older samples) plus the incoming din.
  logic [SEQ_LEN-1:0] r_pat,  w_pat_nxt;
  logic [SEQ_LEN-2:0] r_hist, w_hist_nxt;
  logic [PS_W-1:0]    r_fill, w_fill_nxt;
  logic [PS_W-1:0]    r_ps,   w_ps_nxt;
  logic [CNT_W-1:0]   r_cnt,  w_cnt_nxt;
  logic               w_hit;

  seq_op_e            w_op;
  logic [SEQ_LEN-1:0] w_hist_sh;
  logic [PS_W-1:0]    w_fill_sh;
  logic [PS_W-1:0]    w_len;
  logic [PS_W-1:0]    w_len_proper;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Pattern load has priority; the sample bit is dropped on a load edge.
  always_comb begin
    w_op = OP_HOLD;
    if (pat_load)       w_op = OP_LOAD;
    else if (din_valid) w_op = OP_SAMPLE;
  end

  assign w_hist_sh = {r_hist, din};
  assign w_fill_sh = (r_fill == PS_W'(SEQ_LEN)) ? r_fill : r_fill + PS_W'(1);
  assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), CNT_W));

  seq_match_len #(
    .SEQ_LEN (SEQ_LEN),
    .PS_W    (PS_W)
  ) u_match_len (
    .i_hist       (w_hist_sh),
    .i_fill       (w_fill_sh),
    .i_pat        (r_pat),
    .o_len        (w_len),
    .o_len_proper (w_len_proper)
  );

  // Next-state logic for pattern, history, state and counter.
  always_comb begin
    w_pat_nxt  = r_pat;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_ps_nxt   = r_ps;
    w_cnt_nxt  = r_cnt;
    w_hit      = 1'b0;
    unique case (w_op)
      OP_LOAD: begin
        w_pat_nxt  = pat_in;
        w_hist_nxt = '0;
        w_fill_nxt = '0;
        w_ps_nxt   = '0;
      end
      OP_SAMPLE: begin
        w_hist_nxt = w_hist_sh[SEQ_LEN-2:0];
        w_fill_nxt = w_fill_sh;
        if (w_len == PS_W'(SEQ_LEN)) begin
          w_hit     = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (overlap) begin
            w_ps_nxt = w_len_proper;
          end else begin
            // Non-overlapping: forget every bit that took part in this match.
            w_fill_nxt = '0;
            w_ps_nxt   = '0;
          end
        end else begin
          w_ps_nxt = w_len;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge fsm_clk or posedge clr) begin
    if (clr) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
      r_ps   <= '0;
      r_cnt  <= '0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_ps   <= w_ps_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

`ifdef SEQ_DET_STRETCH_EN
  logic [STRETCH_W-1:0] r_stretch, w_stretch_nxt;

  // Each match restarts the full stretch window; a pattern load blanks the LED.
  always_comb begin
    w_stretch_nxt = r_stretch;
    if (w_op == OP_LOAD)        w_stretch_nxt = '0;
    else if (w_hit)             w_stretch_nxt = '1;
    else if (r_stretch != '0)   w_stretch_nxt = r_stretch - STRETCH_W'(1);
  end

  always_ff @(posedge fsm_clk or posedge clr) begin
    if (clr) r_stretch <= '0;
    else     r_stretch <= w_stretch_nxt;
  end

  assign seq_det = (r_stretch != '0);
`else
  logic r_det;

  always_ff @(posedge fsm_clk or posedge clr) begin
    if (clr) r_det <= 1'b0;
    else     r_det <= w_hit;
  end

  assign seq_det = r_det;
`endif

  assign match_cnt = r_cnt;
  assign ps        = r_ps;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a queue-based reference model
// predicts each edge's outputs, a monitor compares them one edge later.
module tb_seq_detector_param;

  localparam int unsigned N       = 4;
  localparam int unsigned PS_W    = 3;
  localparam longint      STR_MAX = (64'd1 << 24) - 1;

  logic            fsm_clk;
  logic            clr;
  logic            din;
  logic            din_valid;
  logic            overlap;
  logic            pat_load;
  logic [N-1:0]    pat_in;
  logic            seq_det,  seq_det2;
  logic [7:0]      match_cnt;
  logic [1:0]      match_cnt2;
  logic [PS_W-1:0] ps, ps2;

  seq_detector_param dut (
    .fsm_clk   (fsm_clk),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .seq_det   (seq_det),
    .match_cnt (match_cnt),
    .ps        (ps)
  );

  seq_detector_param #(.CNT_W(2)) dut_sat (
    .fsm_clk   (fsm_clk),
    .clr       (clr),
    .din       (din),
    .din_valid (din_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .seq_det   (seq_det2),
    .match_cnt (match_cnt2),
    .ps        (ps2)
  );

  initial fsm_clk = 1'b0;
  always #5 fsm_clk = ~fsm_clk;

  typedef struct {
    logic det;
    int   cnt;
    int   cnt2;
    int   ps;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: received bits as a queue, pattern as a plain vector.
  bit         rx[$];
  logic [3:0] m_pat = 4'b1010;
  int         m_ps = 0, m_cnt = 0, m_cnt2 = 0;
  bit         m_det = 0;
  longint     m_str = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Longest k<=maxk where the newest k received bits equal the first k pattern bits.
  function automatic int longest(input int maxk);
    int best = 0;
    for (int k = 1; k <= maxk; k++) begin
      bit ok = 1'b1;
      if (k > rx.size()) break;
      for (int j = 0; j < k; j++)
        if (rx[rx.size() - k + j] != m_pat[N - 1 - j]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic model(input bit d, input bit v, input bit ov, input bit ld,
                       input logic [3:0] pi, input bit c);
    int L;
    if (c) begin
      rx.delete(); m_pat = 4'b1010; m_ps = 0; m_cnt = 0; m_cnt2 = 0; m_det = 0; m_str = 0;
    end else if (ld) begin
      m_pat = pi; rx.delete(); m_ps = 0; m_det = 0; m_str = 0;
    end else begin
      m_det = 0;
      if (m_str > 0) m_str--;
      if (v) begin
        rx.push_back(d);
        if (rx.size() > N) void'(rx.pop_front());
        L = longest(N);
        if (L == N) begin
          m_det  = 1;
          m_str  = STR_MAX;
          m_cnt  = (m_cnt  == 255) ? 255 : m_cnt + 1;
          m_cnt2 = (m_cnt2 == 3)   ? 3   : m_cnt2 + 1;
          if (ov) m_ps = longest(N - 1);
          else begin rx.delete(); m_ps = 0; end
        end else begin
          m_ps = L;
        end
      end
    end
  endtask

  // One clock edge of stimulus; the expectation for that edge goes to the scoreboard.
  task automatic step(input bit d, input bit v, input bit ov, input bit ld,
                      input logic [3:0] pi, input bit c);
    exp_t e;
    @(posedge fsm_clk); #2;
    din = d; din_valid = v; overlap = ov; pat_load = ld; pat_in = pi; clr = c;
    model(d, v, ov, ld, pi, c);
`ifdef SEQ_DET_STRETCH_EN
    e.det = (m_str != 0);
`else
    e.det = m_det;
`endif
    e.cnt = m_cnt; e.cnt2 = m_cnt2; e.ps = m_ps;
    sb.push_back(e);
    if (c) begin
      #1;
      check("clr_async_ps",  32'(ps),        32'd0);
      check("clr_async_det", 32'(seq_det),   32'd0);
      check("clr_async_cnt", 32'(match_cnt), 32'd0);
    end
  endtask

  task automatic bit_in(input bit d, input bit ov);
    step(d, 1'b1, ov, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic gap(input bit d);
    step(d, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic do_clr();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
  endtask

  // Monitor: every edge the DUT presents fresh outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge fsm_clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("seq_det",       32'(seq_det),    32'(e.det));
        check("match_cnt",     32'(match_cnt),  32'(e.cnt));
        check("ps",            32'(ps),         32'(e.ps));
        check("match_cnt_sat", 32'(match_cnt2), 32'(e.cnt2));
      end
    end
  end

  localparam bit S1010101 [7] = '{1, 0, 1, 0, 1, 0, 1};

  initial begin
    int r;
    clr = 1'b1; din = 1'b0; din_valid = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = '0;

    // Reset state, then the default pattern with overlap.
    do_clr();
    for (int i = 0; i < 7; i++) bit_in(S1010101[i], 1'b1);

    // Same stream, non-overlapping.
    do_clr();
    for (int i = 0; i < 7; i++) bit_in(S1010101[i], 1'b0);

    // Reload pattern mid-stream; then a load colliding with a sample.
    bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0);
    bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b1101, 1'b0);
    bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0);

    // Gaps with din toggling while din_valid is low.
    do_clr();
    for (int i = 0; i < 7; i++) begin
      bit_in(S1010101[i], 1'b1);
      gap(~S1010101[i]);
      gap(S1010101[i]);
    end

    // Clear between bits 3 and 4 of 1010.
    do_clr();
    bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
    do_clr();
    bit_in(1'b0, 1'b1);

    // Saturation of the narrow counter: many overlapping matches.
    for (int i = 0; i < 12; i++) bit_in(1'(i % 2 == 0), 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0)
        do_clr();
      else if (r < 6)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b1, 4'($urandom), 1'b0);
      else
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             1'b0, 4'($urandom), 1'b0);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge fsm_clk);
    #3;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
